tlb_op_controller: RTL
======================

Name: tlb_op_controller

Overview:
- Sequences the four CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the shared TLB array's single index, write and probe port.
- Owns the CP0 Random register, including Wired-bounded wrap-around.
- Presents a one-op-at-a-time valid/ready interface to the pipeline's CP0 stage and returns probe/read results for CP0 writeback.
- Pulses a flush after every TLB write so micro-TLBs and translation caches drop stale mappings.

Parameters:
- TLB_NUM, 32, number of TLB entries; must be a power of two, at least 2.
- IDX_BITS, $clog2(TLB_NUM), width of an entry index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- op_valid  in  1  TLB instruction request.
- op_type  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
- op_ready  out  1  controller idle; accepts op when op_valid && op_ready.
- cp0_index  in  IDX_BITS  CP0 Index field, used by TLBR and TLBWI.
- cp0_entryhi  in  32  CP0 EntryHi.
- cp0_entrylo0  in  32  CP0 EntryLo0.
- cp0_entrylo1  in  32  CP0 EntryLo1.
- cp0_pagemask  in  12  CP0 PageMask[24:13].
- cp0_wired  in  IDX_BITS  CP0 Wired value.
- cp0_wired_we  in  1  Wired being written this cycle.
- tlb_we  out  1  TLB array write strobe.
- tlb_index  out  IDX_BITS  TLB read/write index.
- tlb_mask  out  12  TLB write mask.
- tlb_entryhi  out  32  TLB write/probe EntryHi.
- tlb_entrylo0  out  32  TLB write EntryLo0.
- tlb_entrylo1  out  32  TLB write EntryLo1.
- tlb_mask_rd  in  12  TLB read mask.
- tlb_entryhi_rd  in  32  TLB read EntryHi.
- tlb_entrylo0_rd  in  32  TLB read EntryLo0.
- tlb_entrylo1_rd  in  32  TLB read EntryLo1.
- tlb_probe_index  in  32  TLB probe result; bit31 set on miss.
- done  out  1  one-cycle pulse when the op completes.
- res_index_we  out  1  write res_index into CP0 Index (TLBP).
- res_index  out  32  probe result.
- res_entry_we  out  1  write res_* into EntryHi/Lo0/Lo1/PageMask (TLBR).
- res_entryhi  out  32  read result.
- res_entrylo0  out  32  read result.
- res_entrylo1  out  32  read result.
- res_pagemask  out  12  read result.
- random_o  out  IDX_BITS  CP0 Random value.
- flush_o  out  1  one-cycle pulse after a TLB write.

Behaviour:
- States: IDLE, PROBE, READ, WRITE, DONE. Reset state is IDLE.
- Reset values:
  - op_ready=1.
  - tlb_we, done, res_index_we, res_entry_we, flush_o all 0.
  - res_* registers 0.
  - random_o=TLB_NUM-1.
  - tlb_* data outputs 0.
- Accept (IDLE, op_valid && op_ready):
  - Latch op_type and all cp0_* operands into holding registers.
  - For TLBWR, also snapshot random_o as the write index.
  - Next state: TLBP→PROBE, TLBR→READ, TLBWI/TLBWR→WRITE.
  - op_ready=0 in every state except IDLE.
- tlb_* outputs are driven combinationally from the holding registers in every state, so the TLB sees stable operands for the whole op:
  - tlb_index = latched cp0_index, or the Random snapshot for TLBWR.
  - tlb_entryhi, tlb_entrylo0, tlb_entrylo1, tlb_mask = latched values.
- PROBE: hold one cycle; at its clock edge register res_index <= tlb_probe_index.
- READ: hold one cycle; at its clock edge register res_entryhi, res_entrylo0, res_entrylo1 and res_pagemask from the tlb_*_rd inputs.
- WRITE: tlb_we=1 for exactly this one cycle; asserted in no other state.
- DONE (one cycle, then IDLE):
  - done=1.
  - res_index_we=1 if TLBP; res_entry_we=1 if TLBR; flush_o=1 if TLBWI or TLBWR.
  - The res_* registers hold their values until the next capture.
- Latency: accepted at edge T, done high in the cycle after edge T+1; throughput is one op per 3 cycles. A new op may be accepted on the edge that leaves DONE only if op_ready is high, i.e. the cycle after DONE.
- Random register:
  - Each cycle: if random_o <= cp0_wired, it becomes TLB_NUM-1; otherwise it decrements by 1.
  - The sequence never goes below cp0_wired.
  - cp0_wired_we=1 forces TLB_NUM-1 and takes priority over decrement.
  - If cp0_wired >= TLB_NUM-1, random_o stays at TLB_NUM-1.
  - Random keeps counting during ops; TLBWR uses only the value snapshotted at accept.
- op_valid while busy is ignored; the requester holds it until accepted.
- op_type and cp0_* changes after accept have no effect on the op in flight.
- Reset mid-operation returns to IDLE immediately. No tlb_we or done is issued, including a reset asserted during WRITE (the write strobe drops asynchronously).

Test Plan:
- TLBWI: cp0_index=5, entryhi=0x00402001, lo0=0x00000017, lo1=0x0000005F → tlb_we high exactly 1 cycle with tlb_index=5 and the same data; done and flush_o pulse on the next cycle; op_ready low for 2 cycles.
- TLBP hit and miss: tlb_probe_index=0x00000007 → res_index=7, res_index_we=done=1 for one cycle. Repeat with 0x80000000 → res_index=0x80000000.
- TLBR: cp0_index=3, tlb returns mask 0x003, entryhi 0x12346000 → res_pagemask=0x003, res_entryhi=0x12346000, res_entry_we pulses; no tlb_we.
- Random: wired=4 → random_o sequence 31, 30, …, 5, 4, 31. cp0_wired_we mid-count → 31 next cycle. wired=31 → constant 31.
- TLBWR: accept when random_o=17 → tlb_index=17 during WRITE even though random_o has since advanced to 16.
- Reset asserted in the WRITE cycle → tlb_we drops immediately; no done or flush_o; op_ready=1 and random_o=31 after release.

Source files
------------

// File: rtl/tlb_op_controller.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR against the shared TLB port and owns the
// CP0 Random register with Wired-bounded wrap-around.
module tlb_op_controller #(
  parameter int TLB_NUM  = 32,
  parameter int IDX_BITS = $clog2(TLB_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [1:0]          op_type,
  output logic                op_ready,
  input  logic [IDX_BITS-1:0] cp0_index,
  input  logic [31:0]         cp0_entryhi,
  input  logic [31:0]         cp0_entrylo0,
  input  logic [31:0]         cp0_entrylo1,
  input  logic [11:0]         cp0_pagemask,
  input  logic [IDX_BITS-1:0] cp0_wired,
  input  logic                cp0_wired_we,
  output logic                tlb_we,
  output logic [IDX_BITS-1:0] tlb_index,
  output logic [11:0]         tlb_mask,
  output logic [31:0]         tlb_entryhi,
  output logic [31:0]         tlb_entrylo0,
  output logic [31:0]         tlb_entrylo1,
  input  logic [11:0]         tlb_mask_rd,
  input  logic [31:0]         tlb_entryhi_rd,
  input  logic [31:0]         tlb_entrylo0_rd,
  input  logic [31:0]         tlb_entrylo1_rd,
  input  logic [31:0]         tlb_probe_index,
  output logic                done,
  output logic                res_index_we,
  output logic [31:0]         res_index,
  output logic                res_entry_we,
  output logic [31:0]         res_entryhi,
  output logic [31:0]         res_entrylo0,
  output logic [31:0]         res_entrylo1,
  output logic [11:0]         res_pagemask,
  output logic [IDX_BITS-1:0] random_o,
  output logic                flush_o
);

  typedef enum logic [2:0] {S_IDLE, S_PROBE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] OP_TLBP = 2'd0;
  localparam logic [1:0] OP_TLBR = 2'd1;
  localparam logic [IDX_BITS-1:0] RAND_MAX = IDX_BITS'(TLB_NUM - 1);

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [31:0]         hi_q, lo0_q, lo1_q;
  logic [11:0]         mask_q;
  logic [IDX_BITS-1:0] rand_q, rand_d;
  logic [31:0]         res_index_q, res_hi_q, res_lo0_q, res_lo1_q;
  logic [11:0]         res_mask_q;
  logic                accept;

  assign accept = op_valid && (state_q == S_IDLE);

  // Random never drops below Wired; a Wired write restarts it from the top.
  assign rand_d = (cp0_wired_we || (rand_q <= cp0_wired)) ? RAND_MAX : rand_q - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          unique case (op_type)
            2'd0:    state_d = S_PROBE;
            2'd1:    state_d = S_READ;
            default: state_d = S_WRITE;
          endcase
        end
      end
      S_PROBE, S_READ, S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready     = 1'b0;
    tlb_we       = 1'b0;
    done         = 1'b0;
    res_index_we = 1'b0;
    res_entry_we = 1'b0;
    flush_o      = 1'b0;
    unique case (state_q)
      S_IDLE:  op_ready = 1'b1;
      S_WRITE: tlb_we   = 1'b1;
      S_DONE: begin
        done         = 1'b1;
        res_index_we = (op_q == OP_TLBP);
        res_entry_we = (op_q == OP_TLBR);
        flush_o      = op_q[1];
      end
      default: ;
    endcase
  end

  // Operand holding registers, result capture and Random.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= 2'd0;
      idx_q       <= '0;
      hi_q        <= 32'd0;
      lo0_q       <= 32'd0;
      lo1_q       <= 32'd0;
      mask_q      <= 12'd0;
      rand_q      <= RAND_MAX;
      res_index_q <= 32'd0;
      res_hi_q    <= 32'd0;
      res_lo0_q   <= 32'd0;
      res_lo1_q   <= 32'd0;
      res_mask_q  <= 12'd0;
    end else begin
      rand_q <= rand_d;
      if (accept) begin
        op_q   <= op_type;
        idx_q  <= (op_type == 2'd3) ? rand_q : cp0_index;
        hi_q   <= cp0_entryhi;
        lo0_q  <= cp0_entrylo0;
        lo1_q  <= cp0_entrylo1;
        mask_q <= cp0_pagemask;
      end
      if (state_q == S_PROBE) res_index_q <= tlb_probe_index;
      if (state_q == S_READ) begin
        res_hi_q   <= tlb_entryhi_rd;
        res_lo0_q  <= tlb_entrylo0_rd;
        res_lo1_q  <= tlb_entrylo1_rd;
        res_mask_q <= tlb_mask_rd;
      end
    end
  end

  assign tlb_index    = idx_q;
  assign tlb_entryhi  = hi_q;
  assign tlb_entrylo0 = lo0_q;
  assign tlb_entrylo1 = lo1_q;
  assign tlb_mask     = mask_q;
  assign res_index    = res_index_q;
  assign res_entryhi  = res_hi_q;
  assign res_entrylo0 = res_lo0_q;
  assign res_entrylo1 = res_lo1_q;
  assign res_pagemask = res_mask_q;
  assign random_o     = rand_q;

endmodule
